// File: rtl/dm_access_ctrl.sv
// rtl/dm_access_ctrl.sv - M-stage data-memory access sequencer
// Alignment check, byte-lane steering, bus handshake with timeout, and response capture.
module dm_access_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        flush,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        bus_req,
   output logic [31:0] m_data_addr,
   output logic [31:0] m_data_wdata,
   output logic [3:0]  m_data_byteen,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata,
   output logic [1:0]  ext_A,
   output logic [2:0]  ext_Op,
   output logic        exc_adel,
   output logic        exc_ades,
   output logic        bus_err
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             killed;

   logic             is_store;
   logic             misaligned;
   logic [3:0]       byteen_c;
   logic [31:0]      wdata_c;
   logic             kill_now;
   logic             busy_is_load;
   logic             last_wait;

   assign is_store  = req_op[0];
   assign kill_now  = killed | flush;
   assign last_wait = (cnt == CNT_W'(TIMEOUT - 1));
   // Loads are the only accesses issued with all byte enables clear.
   assign busy_is_load = (m_data_byteen == 4'b0000);
   assign stall = req_valid & ~flush & (state != RESP);

   always_comb begin
      misaligned = 1'b0;
      byteen_c   = 4'b0000;
      wdata_c    = req_wdata;
      case (req_op[2:1])
         2'b01: begin
            byteen_c = 4'b0001 << req_addr[1:0];
            wdata_c  = {4{req_wdata[7:0]}};
         end
         2'b10: begin
            misaligned = req_addr[0];
            byteen_c   = req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_c    = {2{req_wdata[15:0]}};
         end
         default: begin
            misaligned = (req_addr[1:0] != 2'b00);
            byteen_c   = 4'b1111;
         end
      endcase
      if (!is_store) byteen_c = 4'b0000;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         cnt           <= '0;
         killed        <= 1'b0;
         bus_req       <= 1'b0;
         m_data_addr   <= '0;
         m_data_wdata  <= '0;
         m_data_byteen <= '0;
         done          <= 1'b0;
         rdata         <= '0;
         ext_A         <= '0;
         ext_Op        <= '0;
         exc_adel      <= 1'b0;
         exc_ades      <= 1'b0;
         bus_err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && !flush) begin
                  if (misaligned) begin
                     state    <= RESP;
                     done     <= 1'b1;
                     exc_adel <= ~is_store;
                     exc_ades <= is_store;
                  end else begin
                     state         <= BUSY;
                     bus_req       <= 1'b1;
                     m_data_addr   <= {req_addr[31:2], 2'b00};
                     m_data_wdata  <= wdata_c;
                     m_data_byteen <= byteen_c;
                     ext_A         <= req_addr[1:0];
                     ext_Op        <= {req_op[2:1], 1'b0};
                     cnt           <= '0;
                     killed        <= 1'b0;
                  end
               end
            end
            BUSY: begin
               if (flush) killed <= 1'b1;
               // Ack wins over a timeout that expires in the same cycle.
               if (bus_ack) begin
                  bus_req <= 1'b0;
                  if (kill_now) begin
                     state  <= IDLE;
                     killed <= 1'b0;
                  end else begin
                     state <= RESP;
                     done  <= 1'b1;
                     if (busy_is_load) rdata <= bus_rdata;
                  end
               end else if (last_wait) begin
                  bus_req <= 1'b0;
                  if (kill_now) begin
                     state  <= IDLE;
                     killed <= 1'b0;
                  end else begin
                     state   <= RESP;
                     done    <= 1'b1;
                     bus_err <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RESP: begin
               state    <= IDLE;
               done     <= 1'b0;
               exc_adel <= 1'b0;
               exc_ades <= 1'b0;
               bus_err  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb/tb_dm_access_ctrl.sv - self-checking bench for dm_access_ctrl
// Vector table, directed corner sequences, and random accesses against a transaction model.
module tb_dm_access_ctrl;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        flush;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        bus_req;
   logic [31:0] m_data_addr;
   logic [31:0] m_data_wdata;
   logic [3:0]  m_data_byteen;
   logic        stall;
   logic        done;
   logic [31:0] rdata;
   logic [1:0]  ext_A;
   logic [2:0]  ext_Op;
   logic        exc_adel;
   logic        exc_ades;
   logic        bus_err;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_rdata;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          ack_at;
      logic [31:0] rd;
      logic [3:0]  byteen;
      logic [31:0] mwdata;
      bit          adel;
      bit          ades;
      bit          err;
      int          req_cycles;
   } vec_t;

   dm_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_req(bus_req),
      .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
      .m_data_byteen(m_data_byteen), .stall(stall), .done(done),
      .rdata(rdata), .ext_A(ext_A), .ext_Op(ext_Op),
      .exc_adel(exc_adel), .exc_ades(exc_ades), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mkv(input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input int ack_at,
                                input logic [31:0] rd, input logic [3:0] byteen,
                                input logic [31:0] mwdata, input bit adel,
                                input bit ades, input bit err, input int req_cycles);
      vec_t v;
      v.op = op; v.addr = addr; v.wdata = wdata; v.ack_at = ack_at; v.rd = rd;
      v.byteen = byteen; v.mwdata = mwdata; v.adel = adel; v.ades = ades;
      v.err = err; v.req_cycles = req_cycles;
      return v;
   endfunction

   // Access size in bytes decides everything: alignment, lane mask, replication.
   function automatic vec_t model(input logic [2:0] op, input logic [31:0] addr,
                                  input logic [31:0] wdata, input int ack_at,
                                  input logic [31:0] rd);
      int n;
      bit st, mis, acked;
      logic [3:0] be;
      logic [31:0] wd;
      n   = (op[2:1] == 2'b00) ? 4 : (op[2:1] == 2'b01) ? 1 : 2;
      st  = op[0];
      mis = (int'(addr % 4) % n) != 0;
      be  = st ? 4'(((1 << n) - 1) << int'(addr & 32'(4 - n))) : 4'b0000;
      wd  = (n == 4) ? wdata : (n == 2) ? (wdata & 32'hFFFF) * 32'h0001_0001
                                        : (wdata & 32'hFF) * 32'h0101_0101;
      acked = (ack_at >= 1) && (ack_at <= TIMEOUT);
      return mkv(op, addr, wdata, ack_at, rd, be, wd, mis && !st, mis && st,
                 !mis && !acked, mis ? 0 : (acked ? ack_at : TIMEOUT));
   endfunction

   task automatic run_txn(input vec_t v);
      int  req_cnt, stall_cnt;
      bit  seen_done;
      bit  mis;
      logic [31:0] waddr;
      waddr = v.addr & 32'hFFFF_FFFC;
      mis   = v.adel || v.ades;
      @(negedge clk);
      req_valid = 1'b1; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
      bus_ack = 1'b0; flush = 1'b0;
      #1;
      stall_cnt = stall ? 1 : 0;
      req_cnt = 0;
      seen_done = 1'b0;
      for (int c = 1; c <= 40 && !seen_done; c++) begin
         @(negedge clk);
         if (done) begin
            seen_done = 1'b1;
            if (!v.op[0] && !mis && !v.err) last_rdata = v.rd;
            chk("resp_stall", 32'(stall), 32'd0);
            chk("resp_bus_req", 32'(bus_req), 32'd0);
            chk("exc_adel", 32'(exc_adel), 32'(v.adel));
            chk("exc_ades", 32'(exc_ades), 32'(v.ades));
            chk("bus_err", 32'(bus_err), 32'(v.err));
            chk("rdata", rdata, last_rdata);
            if (!v.op[0] && !mis) begin
               chk("ext_A", 32'(ext_A), 32'(v.addr[1:0]));
               chk("ext_Op", 32'(ext_Op), 32'(v.op));
            end
            req_valid = 1'b0;
         end else begin
            if (stall) stall_cnt++;
            if (bus_req) begin
               req_cnt++;
               chk("m_data_addr", m_data_addr, waddr);
               chk("m_data_byteen", 32'(m_data_byteen), 32'(v.byteen));
               if (v.op[0]) chk("m_data_wdata", m_data_wdata, v.mwdata);
            end
            bus_ack   = (c == v.ack_at);
            bus_rdata = (c == v.ack_at) ? v.rd : $urandom;
         end
      end
      bus_ack = 1'b0;
      req_valid = 1'b0;
      chk("done_seen", 32'(seen_done), 32'd1);
      chk("bus_req_cycles", 32'(req_cnt), 32'(v.req_cycles));
      chk("stall_cycles", 32'(stall_cnt), 32'(v.req_cycles + 1));
      @(negedge clk);
      chk("done_once", 32'(done), 32'd0);
      chk("flags_clear", {29'd0, exc_adel, exc_ades, bus_err}, 32'd0);
   endtask

   vec_t tbl[12];
   logic [2:0] ops[6];

   initial begin
      reset = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
      flush = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
      last_rdata = '0;
      ops[0] = 3'b000; ops[1] = 3'b010; ops[2] = 3'b100;
      ops[3] = 3'b001; ops[4] = 3'b011; ops[5] = 3'b101;

      tbl[0]  = mkv(3'b011, 32'h0000_3002, 32'h0000_00A5, 1,  32'h0,         4'b0100, 32'hA5A5_A5A5, 0, 0, 0, 1);
      tbl[1]  = mkv(3'b010, 32'h0000_0013, 32'h0,         4,  32'h80FF_0000, 4'b0000, 32'h0,         0, 0, 0, 4);
      tbl[2]  = mkv(3'b100, 32'h0000_0001, 32'h0,         1,  32'h0,         4'b0000, 32'h0,         1, 0, 0, 0);
      tbl[3]  = mkv(3'b001, 32'h0000_0002, 32'h1111_2222, 1,  32'h0,         4'b1111, 32'h1111_2222, 0, 1, 0, 0);
      tbl[4]  = mkv(3'b000, 32'h0000_0100, 32'h0,         0,  32'h0,         4'b0000, 32'h0,         0, 0, 1, 16);
      tbl[5]  = mkv(3'b000, 32'h0000_0104, 32'h0,         16, 32'hCAFE_F00D, 4'b0000, 32'h0,         0, 0, 0, 16);
      tbl[6]  = mkv(3'b101, 32'h0000_0202, 32'h1234_BEEF, 2,  32'h5555_5555, 4'b1100, 32'hBEEF_BEEF, 0, 0, 0, 2);
      tbl[7]  = mkv(3'b101, 32'h0000_0200, 32'h0000_7A3C, 1,  32'h0,         4'b0011, 32'h7A3C_7A3C, 0, 0, 0, 1);
      tbl[8]  = mkv(3'b001, 32'h0000_0400, 32'hDEAD_BEEF, 3,  32'h0,         4'b1111, 32'hDEAD_BEEF, 0, 0, 0, 3);
      tbl[9]  = mkv(3'b100, 32'h0000_0003, 32'h0,         1,  32'h0,         4'b0000, 32'h0,         1, 0, 0, 0);
      tbl[10] = mkv(3'b011, 32'h0000_0001, 32'h1234_5677, 2,  32'h0,         4'b0010, 32'h7777_7777, 0, 0, 0, 2);
      tbl[11] = mkv(3'b000, 32'h0000_0001, 32'h0,         1,  32'h0,         4'b0000, 32'h0,         1, 0, 0, 0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_bus_req", 32'(bus_req), 32'd0);
      chk("rst_outputs", {m_data_addr | m_data_wdata | rdata}, 32'd0);
      chk("rst_small", {20'd0, m_data_byteen, done, ext_A, ext_Op, exc_adel, exc_ades, bus_err}, 32'd0);
      reset = 1'b1;

      for (int i = 0; i < 12; i++) run_txn(tbl[i]);

      // Flush in IDLE: request must not be taken.
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'b000; req_addr = 32'h40; flush = 1'b1;
      #1 chk("idle_flush_stall", 32'(stall), 32'd0);
      repeat (2) @(negedge clk);
      chk("idle_flush_noreq", 32'(bus_req | done), 32'd0);
      req_valid = 1'b0; flush = 1'b0;

      // Kill while BUSY: transaction completes on the bus, no response.
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'b101; req_addr = 32'h0000_0802; req_wdata = 32'h0000_1234;
      @(negedge clk);
      chk("kill_bus_req", 32'(bus_req), 32'd1);
      flush = 1'b1; req_valid = 1'b0;
      #1 chk("kill_stall", 32'(stall), 32'd0);
      @(negedge clk);
      flush = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h9999_9999;
      @(negedge clk);
      bus_ack = 1'b0;
      chk("kill_req_drop", 32'(bus_req), 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk("kill_no_resp", {28'd0, done, exc_adel, exc_ades, bus_err}, 32'd0);
         @(negedge clk);
      end
      run_txn(model(3'b000, 32'h0000_0900, 32'h0, 2, 32'h1357_9BDF));

      // Reset in the middle of BUSY; a late ack must be ignored.
      @(negedge clk);
      req_valid = 1'b1; req_op = 3'b000; req_addr = 32'h0000_0A00;
      @(negedge clk);
      chk("rstbusy_req", 32'(bus_req), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      chk("rstbusy_bus_req", 32'(bus_req), 32'd0);
      chk("rstbusy_words", {m_data_addr | m_data_wdata | rdata}, 32'd0);
      chk("rstbusy_small", {20'd0, m_data_byteen, done, ext_A, ext_Op, exc_adel, exc_ades, bus_err}, 32'd0);
      reset = 1'b1; req_valid = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      bus_ack = 1'b0;
      chk("late_ack_ignored", {30'd0, done, bus_req}, 32'd0);
      chk("late_ack_rdata", rdata, 32'd0);
      last_rdata = '0;

      for (int i = 0; i < 40; i++) begin
         logic [2:0] op;
         op = ops[$urandom_range(0, 5)];
         run_txn(model(op, $urandom, $urandom, int'($urandom_range(0, 18)), $urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Sequences every M-stage data-memory access of the pipelined CPU onto the external data bus (m_data_* / req-ack handshake).
- Generates byte enables and store-data lane replication, and checks alignment (AdEL/AdES).
- Stalls the pipeline until the bus acknowledges, captures read data, and supplies the captured word plus the A/Op selects to the load extender.
- Bounds every bus wait with a timeout.

Parameters:
- TIMEOUT, 16, maximum BUSY cycles without bus_ack before bus error (≥2).
- CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  M stage holds a load/store
- req_op  in  3  000 LW, 010 LB, 100 LH, 001 SW, 011 SB, 101 SH; bit0 = store
- req_addr  in  32  byte address
- req_wdata  in  32  store data (right-aligned)
- flush  in  1  exception/interrupt kill of the M-stage instruction
- bus_ack  in  1  bus completes transaction
- bus_rdata  in  32  read word, valid with bus_ack
- bus_req  out  1  transaction request, held until ack/timeout
- m_data_addr  out  32  word-aligned address {addr[31:2],2'b00}
- m_data_wdata  out  32  lane-replicated store data
- m_data_byteen  out  4  write byte enables (0000 for loads)
- stall  out  1  freeze F/D/E/M
- done  out  1  one-cycle response pulse
- rdata  out  32  captured bus word (to extender m_data_rdata)
- ext_A  out  2  captured addr[1:0]
- ext_Op  out  3  captured load op (000/010/100)
- exc_adel  out  1  load misalignment, valid with done
- exc_ades  out  1  store misalignment, valid with done
- bus_err  out  1  timeout, valid with done

Behaviour:
- Reset (reset==0 at edge, any state): state IDLE, counter 0, killed 0. All registered outputs 0: bus_req, m_data_*, done, rdata, ext_A, ext_Op, exc_*, bus_err. Reset mid-BUSY drops bus_req next cycle; no done is generated.
- States: IDLE, BUSY, RESP.
- IDLE, req_valid=1, flush=0: accept.
  - Misaligned (LW/SW addr[1:0]≠0; LH/SH addr[0]≠0): go to RESP with exc_adel (load) or exc_ades (store); bus_req stays 0.
  - Aligned: go to BUSY. Register bus_req=1, address, byteen, wdata, ext_A, ext_Op; counter cleared.
- IDLE, flush=1: no acceptance.
- Byteen: SW 1111; SH addr[1]?1100:0011; SB 4'b0001<<addr[1:0]; loads 0000.
- Wdata: SW as-is; SH {2{wdata[15:0]}}; SB {4{wdata[7:0]}}.
- BUSY, counting:
  - bus_ack=1: capture bus_rdata into rdata (loads only; stores leave rdata unchanged), drop bus_req, go to RESP.
  - Otherwise the counter increments. When counter==TIMEOUT-1 with no ack: drop bus_req, go to RESP with bus_err=1.
  - An ack and the timeout in the same cycle resolve as ack.
- flush while in BUSY: set killed. The bus transaction still runs to ack/timeout, then go to IDLE with no done and no exc/bus_err.
- RESP: done=1 for exactly one cycle, stall=0; rdata/ext_A/ext_Op/exc_*/bus_err remain valid. Next state is IDLE. Flags clear on leaving RESP, except rdata/ext_A/ext_Op, which hold.
- stall = req_valid & ~flush & (state≠RESP) (combinational). A new request is seen in IDLE the cycle after RESP.
- Latency: aligned access with ack k cycles after bus_req rises responds in cycle k+2 from acceptance. Misaligned access responds in cycle 2.
- bus_req is never re-asserted in the same cycle it drops. m_data_* are stable for the whole time bus_req=1.

Test Plan:
- SB, addr=0x0000_3002, wdata=0x0000_00A5, ack 1 cycle after req → byteen=0100, m_data_addr=0x0000_3000, wdata=0xA5A5_A5A5, bus_req high 1 cycle, done pulse, stall low only in RESP.
- LB, addr=0x0000_0013, ack delayed 3 cycles with bus_rdata=0x80FF_0000 → stall 5 cycles, rdata=0x80FF_0000, ext_A=3, ext_Op=010, done=1 once.
- LH, addr=0x0000_0001 → no bus_req; next cycle done=1, exc_adel=1. Also SW at addr 0x2 → exc_ades=1.
- LW with no ack, TIMEOUT=16 → bus_req high exactly 16 cycles, then done=1, bus_err=1. Separately, ack in the 16th cycle → bus_err=0.
- SH in BUSY; flush pulsed; ack after 2 cycles → no done/exc/bus_err, FSM returns to IDLE, next LW accepted normally.
- reset=0 during BUSY → next cycle bus_req=0, all outputs 0; a late bus_ack is ignored.
